pixel_controller: RTL

Scan sequencer for the 8-digit seven-segment display. It steps a 3-bit digit select (`seg_sel`) through digits 0..7 at a parameterised dwell rate. `seg_sel` drives the nibble mux that picks 4 bits of the 32-bit display word. The block also drives the matching active-low anode enables, inserts a ghost-suppression blank at the end of every digit slot, and marks each completed scan frame.

---
 rtl/pixel_controller.sv | 58 +++++
 1 files changed

// File: rtl/pixel_controller.sv
// Scan sequencer for an 8-digit seven-segment display: digit select, active-low anodes, frame pulse.
// Latency: all outputs registered; seg_sel/anode change together on the slot-boundary edge.
// Backpressure: none; free-running scan, en_mask only gates the anode, never the timing.
module pixel_controller #(
  parameter int TICK_COUNT   = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] en_mask,
  output logic [2:0] seg_sel,
  output logic [7:0] anode,
  output logic       frame_tick
);

  localparam int              CW       = $clog2(TICK_COUNT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TICK_COUNT - 1);
  // Slot positions below this value are lit; the rest of the slot is the blank tail.
  localparam logic [31:0]     LIT_LEN  = 32'(TICK_COUNT - BLANK_CYCLES);

  typedef enum logic [2:0] {
    S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
    S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          slot_end;
  logic          lit_nxt;

  // Next-state slot position; the anode is decoded from it so it lines up with seg_sel/count.
  always_comb begin
    slot_end  = (count == CNT_LAST);
    count_nxt = slot_end ? '0 : count + 1'b1;
    state_nxt = slot_end ? state_t'(state + 3'd1) : state;
    lit_nxt   = ({{(32 - CW){1'b0}}, count_nxt} < LIT_LEN) && en_mask[state_nxt];
  end

  // Slot counter, digit FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      state      <= S0;
      anode      <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      count      <= count_nxt;
      state      <= state_nxt;
      anode      <= lit_nxt ? ~(8'h01 << state_nxt) : 8'hFF;
      frame_tick <= slot_end && (state == S7);
    end
  end

  assign seg_sel = state;

endmodule
